// File: rtl/run_control.sv
// run_control: synchronizes and debounces four operator buttons and sequences
// continuous, single-step and fixed-length burst enables for the even-step counter.
module run_control #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       step_in,
  input  logic       burst_in,
  output logic       run,
  output logic [1:0] mode,
  output logic [7:0] burst_left
);

  localparam int unsigned N_IN  = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
  localparam logic [7:0]       BURST_INIT = 8'(BURST_LEN);

  // Input slot order: 0 start, 1 stop, 2 step, 3 burst
  localparam int unsigned I_START = 0;
  localparam int unsigned I_STOP  = 1;
  localparam int unsigned I_STEP  = 2;
  localparam int unsigned I_BURST = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  r_s1;
  logic [N_IN-1:0]  r_s2;
  logic [N_IN-1:0]  r_db;
  logic [N_IN-1:0]  r_press;
  logic [CNT_W-1:0] r_cnt [N_IN];

  state_t     r_state;
  logic       r_run;
  logic [7:0] r_burst_left;

  assign w_raw = {burst_in, step_in, stop_in, start_in};

  // Two-flop synchronizer, debounce counter and rising-press pulse per input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < N_IN; i++) begin
        r_press[i] <= 1'b0;
        if (r_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]    <= r_s2[i];
          r_cnt[i]   <= '0;
          // Only the 0->1 transition of the debounced value is a press
          r_press[i] <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mode sequencer with registered run enable and burst countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_run        <= 1'b0;
      r_burst_left <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_press[I_STOP]) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end else if (r_press[I_START]) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else if (r_press[I_BURST]) begin
            r_state      <= ST_BURST;
            r_run        <= 1'b1;
            r_burst_left <= BURST_INIT;
          end else if (r_press[I_STEP]) begin
            r_state <= ST_STEP;
            r_run   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_press[I_STOP]) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
          end
        end
        ST_STEP: begin
          r_state <= ST_IDLE;
          r_run   <= 1'b0;
        end
        ST_BURST: begin
          if (r_press[I_STOP] || (r_burst_left == 8'd1)) begin
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
            r_burst_left <= '0;
          end else begin
            r_burst_left <= r_burst_left - 8'd1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_run        <= 1'b0;
          r_burst_left <= '0;
        end
      endcase
    end
  end

  assign run        = r_run;
  assign mode       = r_state;
  assign burst_left = r_burst_left;

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: cycle-by-cycle scoreboard of {run, mode, burst_left} for run_control.
module tb_run_control;

  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned LAT       = DB_CYCLES + 2;

  logic       clk;
  logic       rst;
  logic       start_in;
  logic       stop_in;
  logic       step_in;
  logic       burst_in;
  logic       run;
  logic [1:0] mode;
  logic [7:0] burst_left;

  logic [10:0] exp_q [$];
  int          n_checks;
  int          n_errors;
  string       g_tag;

  run_control #(
    .DB_CYCLES(DB_CYCLES),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_in  (start_in),
    .stop_in   (stop_in),
    .step_in   (step_in),
    .burst_in  (burst_in),
    .run       (run),
    .mode      (mode),
    .burst_left(burst_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue n identical expected cycles
  task automatic push_exp(input int n, input logic r, input logic [1:0] m, input logic [7:0] b);
    for (int i = 0; i < n; i++) exp_q.push_back({r, m, b});
  endtask

  // Queue k burst cycles counting down from BURST_LEN
  task automatic push_burst(input int k);
    for (int i = 0; i < k; i++) exp_q.push_back({1'b1, 2'b11, 8'(BURST_LEN - i)});
  endtask

  task automatic push_idle(input int n);
    push_exp(n, 1'b0, 2'b00, 8'd0);
  endtask

  // Hold inputs for n edges, comparing the DUT to the next expectation after each edge
  task automatic drive(input int n, input logic st, input logic sp, input logic stp,
                       input logic bu, input logic rs);
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      start_in = st;
      stop_in  = sp;
      step_in  = stp;
      burst_in = bu;
      rst      = rs;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check({g_tag, " underflow"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", g_tag, i), 32'({run, mode, burst_left}), 32'(e));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    start_in = 1'b0;
    stop_in  = 1'b0;
    step_in  = 1'b0;
    burst_in = 1'b0;
    rst      = 1'b1;

    // Reset held two cycles with inputs toggling
    g_tag = "reset";
    push_idle(2);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    push_idle(10);
    drive(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start held 10, run latches; stop held 10 from edge 30
    g_tag = "start";
    push_idle(LAT);
    push_exp(10 - LAT, 1'b1, 2'b01, 8'd0);
    drive(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    g_tag = "run_hold";
    push_exp(20, 1'b1, 2'b01, 8'd0);
    drive(20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    g_tag = "stop";
    push_exp(LAT, 1'b1, 2'b01, 8'd0);
    push_idle(10 - LAT);
    drive(10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_idle(12);
    drive(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three-cycle glitch is rejected
    g_tag = "glitch";
    push_idle(23);
    drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full burst
    g_tag = "burst";
    push_idle(LAT);
    push_burst(BURST_LEN);
    push_idle(26 - LAT - BURST_LEN);
    drive(10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Burst cut short by stop raised at edge 3 (press lands at edge 9)
    g_tag = "burst_stop";
    push_idle(LAT);
    push_burst(3);
    push_idle(27 - LAT - 3);
    drive(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held step gives one pulse; a second press gives another
    g_tag = "step1";
    push_idle(LAT);
    push_exp(1, 1'b1, 2'b10, 8'd0);
    push_idle(20 - LAT - 1 + 10);
    drive(20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    g_tag = "step2";
    push_idle(LAT);
    push_exp(1, 1'b1, 2'b10, 8'd0);
    push_idle(10 - LAT - 1 + 10);
    drive(10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start and stop together stay idle
    g_tag = "start_stop";
    push_idle(22);
    drive(10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-burst with burst held, then a fresh burst DB_CYCLES+3 edges later
    g_tag = "rst_burst";
    push_idle(LAT);
    push_burst(3);
    drive(LAT + 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(1);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    g_tag = "rst_reburst";
    push_idle(DB_CYCLES + 2);
    push_burst(BURST_LEN);
    push_idle(20 - (DB_CYCLES + 2) - BURST_LEN);
    drive(20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_idle(15);
    drive(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
